// File: rtl/booth_mult_bist_if.sv
// Operand/result bundle for booth_mult_bist. The master drives operands and
// control; the slave (the multiplier) returns the product and BIST status.
interface booth_mult_bist_if #(parameter int W = 8);
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           start;
  logic           test;
  logic           fault_inj;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;
  logic           bist_done;
  logic           pass;
  logic [15:0]    fail_count;

  modport master (output a, b, start, test, fault_inj,
                  input  product, busy, done, bist_done, pass, fail_count);
  modport slave  (input  a, b, start, test, fault_inj,
                  output product, busy, done, bist_done, pass, fail_count);
endinterface

// File: rtl/booth_mult_bist.sv
// Sequential radix-2 Booth multiplier (signed WxW -> 2W) with a BIST engine that
// sweeps patterns P, P+STRIDE, ... through the same datapath and checks each product.
module booth_mult_bist #(
  parameter int W        = 8,
  parameter int BIST_LEN = 2**(2*W),
  parameter int STRIDE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_mult_bist_if.slave  bus
);
  localparam int PW = 2*W;
  localparam int IW = $clog2(BIST_LEN+1);
  localparam int CW = $clog2(W+1);

  typedef enum logic [2:0] {IDLE, RUN, BIST_LOAD, BIST_RUN, BIST_END} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    q_q, q_d;
  logic [W:0]      a_q, a_d;
  logic            q1_q, q1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [15:0]     fc_q, fc_d;

  logic [W:0]      m_ext, sum;
  logic [PW-1:0]   step_prod, ga, gb, golden;
  logic            last;

  // One Booth step: add/sub on the W+1-bit accumulator; the shift is folded
  // into how the next A/Q values are picked out of sum.
  assign m_ext = {m_q[W-1], m_q};
  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
  end

  assign step_prod = {sum, q_q[W-1:1]} ^ {{(PW-1){1'b0}}, bus.fault_inj};
  assign last      = (cnt_q == CW'(W-1));

  // Golden reference: low 2W bits of a sign-extended multiply equal the signed product
  assign ga     = {{W{p_q[PW-1]}}, p_q[PW-1:W]};
  assign gb     = {{W{p_q[W-1]}},  p_q[W-1:0]};
  assign golden = ga * gb;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    idx_d   = idx_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fc_d    = fc_q;

    if (state_q == RUN || state_q == BIST_RUN) begin
      a_d   = {sum[W], sum[W:1]};
      q_d   = {sum[0], q_q[W-1:1]};
      q1_d  = q_q[0];
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        // The entry edge doubles as the load of pattern 0 (P cleared to zero)
        if (bus.test) begin
          fc_d    = '0;
          pass_d  = 1'b0;
          p_d     = '0;
          idx_d   = '0;
          m_d     = '0;
          q_d     = '0;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = BIST_RUN;
        end else if (bus.start) begin
          m_d     = bus.a;
          q_d     = bus.b;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          prod_d  = step_prod;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      BIST_LOAD: begin
        if (!bus.test) begin
          state_d = IDLE;
        end else begin
          m_d     = p_q[PW-1:W];
          q_d     = p_q[W-1:0];
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = BIST_RUN;
        end
      end
      BIST_RUN: begin
        if (!bus.test) begin
          state_d = IDLE;
        end else if (last) begin
          prod_d = step_prod;
          if (step_prod != golden && fc_q != 16'hFFFF) fc_d = fc_q + 16'd1;
          p_d   = p_q + PW'(STRIDE);
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(BIST_LEN-1)) begin
            pass_d  = (fc_d == 16'd0);
            state_d = BIST_END;
          end else begin
            state_d = BIST_LOAD;
          end
        end
      end
      BIST_END: begin
        if (!bus.test) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      idx_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fc_q    <= fc_d;
    end
  end

  assign bus.product    = prod_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE) && (state_q != BIST_END);
  assign bus.bist_done  = (state_q == BIST_END);
  assign bus.pass       = pass_q;
  assign bus.fail_count = fc_q;
endmodule

// File: tb/tb_booth_mult_bist.sv
// Directed bench: W=4 functional vectors and BIST runs, plus a W=8 strided BIST.
module tb_booth_mult_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  booth_mult_bist_if #(.W(4)) if4 ();
  booth_mult_bist_if #(.W(8)) if8 ();

  booth_mult_bist #(.W(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  booth_mult_bist #(.W(8), .BIST_LEN(1000), .STRIDE(12345)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start is raised in the current cycle; leaves the bench in the done cycle
  task automatic do_mul(input vec_t v);
    if4.a = v.a; if4.b = v.b; if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    if4.a = ~v.a; if4.b = ~v.b;
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy", 32'(if4.busy), 32'd1);
      chk("mul_nodone", 32'(if4.done), 32'd0);
      step();
    end
    chk("mul_done", 32'(if4.done), 32'd1);
    chk("mul_busy_end", 32'(if4.busy), 32'd0);
    chk("mul_product", 32'(if4.product), 32'(v.exp));
  endtask

  // Runs a full W=4 BIST from the current cycle; returns the cycle count to bist_done
  task automatic bist4(input logic with_start, output int n, output logic saw_done);
    if4.test = 1'b1; if4.start = with_start;
    step();
    if4.start = 1'b0;
    n = 1; saw_done = 1'b0;
    while (!if4.bist_done && n < 2000) begin
      if (if4.done) saw_done = 1'b1;
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic sd;
    tv[0] = '{4'h8, 4'h8, 8'h40};  // -8 * -8 = 64
    tv[1] = '{4'h7, 4'h8, 8'hC8};  //  7 * -8 = -56
    tv[2] = '{4'h0, 4'hF, 8'h00};  //  0 * -1 = 0
    tv[3] = '{4'hF, 4'hF, 8'h01};  // -1 * -1 = 1
    tv[4] = '{4'h8, 4'h7, 8'hC8};  // -8 *  7 = -56
    tv[5] = '{4'h5, 4'h3, 8'h0F};  //  5 *  3 = 15
    tv[6] = '{4'h3, 4'hE, 8'hFA};  //  3 * -2 = -6

    if4.a = '0; if4.b = '0; if4.start = 1'b0; if4.test = 1'b0; if4.fault_inj = 1'b0;
    if8.a = '0; if8.b = '0; if8.start = 1'b0; if8.test = 1'b0; if8.fault_inj = 1'b0;
    step(); step();
    chk("rst_product", 32'(if4.product), 32'd0);
    chk("rst_busy", 32'(if4.busy), 32'd0);
    chk("rst_done", 32'(if4.done), 32'd0);
    chk("rst_bist_done", 32'(if4.bist_done), 32'd0);
    chk("rst_pass", 32'(if4.pass), 32'd0);
    chk("rst_fail_count", 32'(if4.fail_count), 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back: each new start is raised in the previous done cycle
    for (int i = 0; i < 7; i++) do_mul(tv[i]);
    step();
    chk("done_one_cycle", 32'(if4.done), 32'd0);
    chk("idle_after", 32'(if4.busy), 32'd0);

    // start and test together: BIST wins, done never pulses
    bist4(1'b1, n, sd);
    chk("bist_cycles", 32'(n), 32'd1280);
    chk("bist_nodone", 32'(sd), 32'd0);
    chk("bist_pass", 32'(if4.pass), 32'd1);
    chk("bist_fc", 32'(if4.fail_count), 32'd0);
    chk("bist_product", 32'(if4.product), 32'd1);
    chk("bist_busy", 32'(if4.busy), 32'd0);
    step();
    chk("bist_hold", 32'(if4.bist_done), 32'd1);
    if4.test = 1'b0;
    step();
    chk("bist_exit_done", 32'(if4.bist_done), 32'd0);
    chk("bist_exit_pass", 32'(if4.pass), 32'd1);

    if4.fault_inj = 1'b1;
    bist4(1'b0, n, sd);
    chk("fbist_cycles", 32'(n), 32'd1280);
    chk("fbist_pass", 32'(if4.pass), 32'd0);
    chk("fbist_fc", 32'(if4.fail_count), 32'd256);
    chk("fbist_product", 32'(if4.product), 32'd0);
    if4.test = 1'b0; if4.fault_inj = 1'b0;
    step();
    chk("fbist_exit_fc", 32'(if4.fail_count), 32'd256);

    // Reset mid-RUN (product is non-zero beforehand)
    do_mul(tv[1]);
    step();
    if4.a = 4'h7; if4.b = 4'h7; if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rstrun_busy", 32'(if4.busy), 32'd0);
    chk("rstrun_product", 32'(if4.product), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Reset mid-BIST with faults accumulating
    if4.fault_inj = 1'b1; if4.test = 1'b1;
    for (int i = 0; i < 100; i++) step();
    chk("rstbist_fc_pre", 32'(if4.fail_count != 0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstbist_busy", 32'(if4.busy), 32'd0);
    chk("rstbist_fc", 32'(if4.fail_count), 32'd0);
    chk("rstbist_product", 32'(if4.product), 32'd0);
    chk("rstbist_bist_done", 32'(if4.bist_done), 32'd0);
    if4.test = 1'b0; if4.fault_inj = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // W=8 strided BIST: last pattern 999*12345 mod 65536 = 0x2E6F, 46*111 = 0x13F2
    if8.test = 1'b1;
    step();
    n = 1;
    while (!if8.bist_done && n < 12000) begin
      step();
      n++;
    end
    chk("w8_cycles", 32'(n), 32'd9000);
    chk("w8_pass", 32'(if8.pass), 32'd1);
    chk("w8_fc", 32'(if8.fail_count), 32'd0);
    chk("w8_product", 32'(if8.product), 32'h13F2);
    if8.test = 1'b0;
    step();
    if8.test = 1'b1;
    for (int i = 0; i < 500; i++) step();
    chk("w8_abort_busy_pre", 32'(if8.busy), 32'd1);
    if8.test = 1'b0;
    step();
    chk("w8_abort_busy", 32'(if8.busy), 32'd0);
    chk("w8_abort_pass", 32'(if8.pass), 32'd0);
    chk("w8_abort_bist_done", 32'(if8.bist_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
